quadrature_emitter: RTL

//  Generates two-phase quadrature A/B waveforms, emulating a mechanical rotary encoder detent by detent.

---
 rtl/quadrature_emitter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/quadrature_emitter.sv
// quadrature_emitter: rotary-encoder emulator. Queued step requests (signed net
// count) are played out as full A/B quadrature detents, one at a time.
// Optional contact bounce on every edge: define QENC_BOUNCE_EN.
module quadrature_emitter #(
  parameter int PHASE_CYCLES  = 4096,
  parameter int CNT_W         = 5,
  parameter int BOUNCE_COUNT  = 3,
  parameter int BOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             step_right,
  input  logic             step_left,
  input  logic             clear,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_P4} state_t;

  localparam int TW = $clog2(PHASE_CYCLES + 1);
  localparam int SW = CNT_W + 2;
  localparam logic [TW-1:0] T_LOAD = TW'(PHASE_CYCLES - 1);
  localparam logic signed [SW-1:0] MAX_P = SW'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [SW-1:0] ONE   = SW'(1);

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                dir_q, dir_d;      // 1 = right (clockwise)
  logic [CNT_W-1:0]    pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                a_q, b_q, busy_q, done_q;
  logic [1:0]          ab_d;
  logic                busy_d, done_d;
  logic                expire, start;
  logic signed [SW-1:0] p_ext, adj, req, sum;

  // AB level for each phase; both directions pass through 00 at P2
  function automatic logic [1:0] ab_of(input state_t s, input logic right);
    case (s)
      S_P1:    ab_of = right ? 2'b10 : 2'b01;
      S_P2:    ab_of = 2'b00;
      S_P3:    ab_of = right ? 2'b01 : 2'b10;
      default: ab_of = 2'b11;
    endcase
  endfunction

  assign expire = (timer_q == '0);
  assign start  = (state_q == S_IDLE) && enable && (pend_q != '0);

  // state, phase timer and latched direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  // next state: each phase held for PHASE_CYCLES via down-counter
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_P1;
          timer_d = T_LOAD;
          dir_d   = ~pend_q[CNT_W-1];
        end
      end
      S_P1, S_P2, S_P3: begin
        if (expire) begin
          state_d = state_t'(state_q + 3'd1);
          timer_d = T_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_P4: begin
        if (expire) state_d = S_IDLE;
        else        timer_d = timer_q - TW'(1);
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // pending queue: request and start-decrement combine; only the request is dropped at saturation
  always_comb begin
    p_ext  = {{2{pend_q[CNT_W-1]}}, pend_q};
    adj    = '0;
    req    = '0;
    sum    = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (start) adj = pend_q[CNT_W-1] ? ONE : -ONE;
    if (step_right && !step_left) req = ONE;
    if (step_left && !step_right) req = -ONE;
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else begin
      sum = p_ext + adj + req;
      if (sum > MAX_P || sum < -MAX_P) begin
        pend_d = CNT_W'(p_ext + adj);
        ovf_d  = 1'b1;
      end else begin
        pend_d = CNT_W'(sum);
      end
    end
  end

  // pending counter and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef QENC_BOUNCE_EN
  // even toggle count so the bouncing line settles at its new level
  localparam int BN  = BOUNCE_COUNT + (BOUNCE_COUNT % 2);
  localparam int BTW = $clog2(BOUNCE_CYCLES + 1);
  localparam int BCW = $clog2(BN + 2);

  if ((BOUNCE_COUNT + 1) * BOUNCE_CYCLES >= PHASE_CYCLES) begin : g_bounce_cfg_err
    $error("bounce train does not fit inside one phase");
  end

  logic [1:0]     bmask_q, bmask_d;
  logic           bflip_q, bflip_d;
  logic [BTW-1:0] btmr_q, btmr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;

  // bounce sequencer: re-arm on every phase change, flip only the line that moved
  always_comb begin
    bmask_d = bmask_q;
    bflip_d = bflip_q;
    btmr_d  = btmr_q;
    bcnt_d  = bcnt_q;
    if (state_d != state_q) begin
      bmask_d = ab_of(state_d, dir_d) ^ ab_of(state_q, dir_q);
      bflip_d = 1'b0;
      bcnt_d  = BCW'(BN);
      btmr_d  = BTW'(BOUNCE_CYCLES - 1);
    end else if (bcnt_q != '0) begin
      if (btmr_q == '0) begin
        bflip_d = ~bflip_q;
        bcnt_d  = bcnt_q - BCW'(1);
        btmr_d  = BTW'(BOUNCE_CYCLES - 1);
      end else begin
        btmr_d  = btmr_q - BTW'(1);
      end
    end
    ab_d = ab_of(state_d, dir_d) ^ (bmask_d & {2{bflip_d}});
  end

  // bounce state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bmask_q <= '0;
      bflip_q <= 1'b0;
      btmr_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      bmask_q <= bmask_d;
      bflip_q <= bflip_d;
      btmr_q  <= btmr_d;
      bcnt_q  <= bcnt_d;
    end
  end
`else
  if (BOUNCE_COUNT < 0 || BOUNCE_CYCLES < 1) begin : g_bounce_cfg_err
    $error("bounce parameters out of range");
  end

  // clean edges: AB follows the next phase directly
  always_comb begin
    ab_d = ab_of(state_d, dir_d);
  end
`endif

  // output decode from next state so every output is a flop
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_P4) && expire;
  end

  // registered outputs; lines idle high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= 1'b1;
      b_q    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= ab_d[1];
      b_q    <= ab_d[0];
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
